// File: rtl/ledfade_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ledfade_pkg
// Brief    : Shared defaults and channel state encodings for the LED fader.
// Revision : 1.0
// ============================================================================
package ledfade_pkg;

    localparam int DEF_N         = 5;
    localparam int DEF_PWM_BITS  = 4;
    localparam int DEF_DECAY_DIV = 4096;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ON   = 2'd1,
        ST_FADE = 2'd2
    } chan_state_t;

endpackage : ledfade_pkg
`default_nettype wire

// File: rtl/ledfade_chan.sv
`default_nettype none
// ============================================================================
// Module   : ledfade_chan
// Brief    : One LED channel: OFF/ON/FADE state, brightness and PWM compare.
// Revision : 1.0
// ============================================================================
module ledfade_chan
    import ledfade_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_din,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    input  logic                i_tick,
    output logic                o_led,
    output logic                o_fade
);

    localparam logic [PWM_BITS-1:0] c_max_bright = '1;
    localparam logic [PWM_BITS-1:0] c_one        = {{(PWM_BITS-1){1'b0}}, 1'b1};

    chan_state_t         r_state;
    logic [PWM_BITS-1:0] r_bright;
    logic                r_led;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= ST_OFF;
            r_bright <= '0;
            r_led    <= 1'b0;
        end else begin
            // Compare uses the pre-edge brightness, so a rise shows one edge later.
            r_led <= (i_pwm_cnt < r_bright);
            if (i_din) begin
                r_state  <= ST_ON;
                r_bright <= c_max_bright;
            end else begin
                case (r_state)
                    ST_ON: begin
                        r_state <= ST_FADE;
                    end
                    ST_FADE: begin
                        if (i_tick) begin
                            if (r_bright <= c_one) begin
                                r_bright <= '0;
                                r_state  <= ST_OFF;
                            end else begin
                                r_bright <= r_bright - c_one;
                            end
                        end
                    end
                    default: begin
                        r_state  <= ST_OFF;
                        r_bright <= '0;
                    end
                endcase
            end
        end
    end

    assign o_led  = r_led;
    assign o_fade = (r_state == ST_FADE);

endmodule : ledfade_chan
`default_nettype wire

// File: rtl/ledfade.sv
`default_nettype none
// ============================================================================
// Module   : ledfade
// Brief    : N-channel LED fader with shared PWM counter and decay prescaler.
// Revision : 1.0
// ============================================================================
module ledfade
    import ledfade_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int PWM_BITS  = DEF_PWM_BITS,
    parameter int DECAY_DIV = DEF_DECAY_DIV
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] din,
    output logic [N-1:0] leds,
    output logic         busy
);

    localparam int PRE_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

    localparam int                  c_pwm_last_i = (1 << PWM_BITS) - 2;
    localparam logic [PWM_BITS-1:0] c_pwm_last   = c_pwm_last_i[PWM_BITS-1:0];
    localparam int                  c_pre_last_i = DECAY_DIV - 1;
    localparam logic [PRE_W-1:0]    c_pre_last   = c_pre_last_i[PRE_W-1:0];

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PRE_W-1:0]    r_pre;
    logic                r_busy;
    logic                w_tick;
    logic [N-1:0]        w_leds;
    logic [N-1:0]        w_fade;

    // With DECAY_DIV == 1 the prescaler is pinned at 0 and tick is always high.
    assign w_tick = (r_pre == c_pre_last);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pwm_cnt <= '0;
            r_pre     <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_pwm_cnt <= (r_pwm_cnt == c_pwm_last) ? '0 : r_pwm_cnt + 1'b1;
            r_pre     <= w_tick ? '0 : r_pre + 1'b1;
            r_busy    <= |w_fade;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            ledfade_chan #(
                .PWM_BITS (PWM_BITS)
            ) u_chan (
                .clk       (clk),
                .rstn      (rstn),
                .i_din     (din[gi]),
                .i_pwm_cnt (r_pwm_cnt),
                .i_tick    (w_tick),
                .o_led     (w_leds[gi]),
                .o_fade    (w_fade[gi])
            );
        end
    endgenerate

    assign leds = w_leds;
    assign busy = r_busy;

endmodule : ledfade
`default_nettype wire

// File: tb/tb_ledfade.sv
`default_nettype none
// ============================================================================
// Module   : tb_ledfade
// Brief    : Directed self-checking bench for ledfade (N=5, MAX=3, DECAY_DIV=2).
// Revision : 1.0
// ============================================================================
module tb_ledfade;

    logic       clk;
    logic       rstn;
    logic [4:0] din;
    logic [4:0] leds;
    logic       busy;

    int n_pass;
    int n_total;

    ledfade #(
        .N         (5),
        .PWM_BITS  (2),
        .DECAY_DIV (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .din  (din),
        .leds (leds),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    // Three reset edges, then release with d_rel; the next posedge is edge e1.
    task automatic do_reset(input logic [4:0] d_rel);
        @(negedge clk);
        rstn = 1'b0;
        din  = 5'b00000;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        din  = d_rel;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn = 1'b0;
        din  = 5'b11111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if (leds !== 5'b00000 || busy !== 1'b0)
                $display("FAIL reset_hold[%0d]: leds=%b busy=%b, want leds=00000 busy=0", i, leds, busy);
            else n_pass++;
        end
        rstn = 1'b1;
        @(negedge clk);
        n_total++;
        if (leds !== 5'b00000 || busy !== 1'b0)
            $display("FAIL reset_rel_e1: leds=%b busy=%b, want leds=00000 busy=0", leds, busy);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (leds !== 5'b11111 || busy !== 1'b0)
            $display("FAIL reset_rel_e2: leds=%b busy=%b, want leds=11111 busy=0", leds, busy);
        else n_pass++;
    endtask

    // din[0] high for e1..e5, low from e6; ticks fall on even edges.
    task automatic test_fade();
        logic [1:14] exp_led;
        logic [1:14] exp_busy;
        exp_led  = 14'b01111111010000;
        exp_busy = 14'b00000011111100;
        do_reset(5'b00001);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            n_total++;
            if (leds !== {4'b0000, exp_led[n]} || busy !== exp_busy[n])
                $display("FAIL fade_e%0d: leds=%b busy=%b, want leds=%b busy=%b",
                         n, leds, busy, {4'b0000, exp_led[n]}, exp_busy[n]);
            else n_pass++;
            if (n == 5) din = 5'b00000;
        end
    endtask

    // Re-assert din[0] at e12, a tick edge where bright=1 would otherwise reach 0.
    task automatic test_reassert();
        logic [1:14] exp_led;
        logic [1:14] exp_busy;
        exp_led  = 14'b01111111010011;
        exp_busy = 14'b00000011111100;
        do_reset(5'b00001);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            n_total++;
            if (leds !== {4'b0000, exp_led[n]} || busy !== exp_busy[n])
                $display("FAIL reassert_e%0d: leds=%b busy=%b, want leds=%b busy=%b",
                         n, leds, busy, {4'b0000, exp_led[n]}, exp_busy[n]);
            else n_pass++;
            if (n == 5)  din = 5'b00000;
            if (n == 11) din = 5'b00001;
        end
    endtask

    task automatic test_parallel();
        logic [4:0]  exp_leds [1:13];
        logic [1:13] exp_busy;
        exp_leds[1]  = 5'b00000;
        exp_leds[2]  = 5'b10101;
        exp_leds[3]  = 5'b10101;
        exp_leds[4]  = 5'b10101;
        exp_leds[5]  = 5'b10101;
        exp_leds[6]  = 5'b10101;
        exp_leds[7]  = 5'b11111;
        exp_leds[8]  = 5'b11111;
        exp_leds[9]  = 5'b01010;
        exp_leds[10] = 5'b11111;
        exp_leds[11] = 5'b01010;
        exp_leds[12] = 5'b01010;
        exp_leds[13] = 5'b01010;
        exp_busy     = 13'b0000001111110;
        do_reset(5'b10101);
        for (int n = 1; n <= 13; n++) begin
            @(negedge clk);
            n_total++;
            if (leds !== exp_leds[n] || busy !== exp_busy[n])
                $display("FAIL parallel_e%0d: leds=%b busy=%b, want leds=%b busy=%b",
                         n, leds, busy, exp_leds[n], exp_busy[n]);
            else n_pass++;
            if (n == 5) din = 5'b01010;
        end
    endtask

    task automatic test_reset_midfade();
        do_reset(5'b00001);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if (n == 5) din = 5'b00000;
        end
        n_total++;
        if (leds !== 5'b00000 || busy !== 1'b1)
            $display("FAIL midfade_pre: leds=%b busy=%b, want leds=00000 busy=1", leds, busy);
        else n_pass++;
        rstn = 1'b0;
        @(negedge clk);
        n_total++;
        if (leds !== 5'b00000 || busy !== 1'b0)
            $display("FAIL midfade_rst: leds=%b busy=%b, want leds=00000 busy=0", leds, busy);
        else n_pass++;
        rstn = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            n_total++;
            if (leds !== 5'b00000 || busy !== 1'b0)
                $display("FAIL midfade_after_e%0d: leds=%b busy=%b, want leds=00000 busy=0",
                         n, leds, busy);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rstn    = 1'b0;
        din     = 5'b00000;
        test_reset();
        test_fade();
        test_reassert();
        test_parallel();
        test_reset_midfade();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_ledfade
`default_nettype wire

// File: doc/ledfade.md
LEDFADE -- requirements
Module: ledfade

Interface
REQ-001 Parameter N, default 5: number of LED channels; legal range 1..16.
REQ-002 Parameter PWM_BITS, default 4: brightness width; MAX = 2^PWM_BITS - 1; legal range 2..8.
REQ-003 Parameter DECAY_DIV, default 4096: clock cycles per decay tick; legal range >= 1.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 din  input  N  LED pattern from the sequencer; bit i requests channel i on; sampled every cycle, no strobe.
REQ-007 leds  output  N  PWM-dimmed LED drive; registered.
REQ-008 busy  output  1  high while any channel is fading; registered.

Function
REQ-009 A free-running PWM counter SHALL count 0..MAX-1 and wrap to 0, giving MAX-cycle periods.
REQ-010 A free-running prescaler SHALL count 0..DECAY_DIV-1 and wrap; tick is high for the one cycle in which prescaler == DECAY_DIV-1.
REQ-011 When DECAY_DIV == 1, tick SHALL be high every cycle.
REQ-012 Each channel SHALL hold a PWM_BITS-wide brightness register bright[i] and a state in {OFF, ON, FADE}.
REQ-013 In OFF with din[i]=0: stay OFF, bright=0.
REQ-014 In any state with din[i]=1: next state ON, bright=MAX; this takes priority over tick.
REQ-015 In ON with din[i]=0: next state FADE, bright unchanged at MAX, even if tick is high in that cycle.
REQ-016 In FADE with din[i]=0 and tick: bright decrements by 1; if the result is 0, next state OFF.
REQ-017 In FADE with din[i]=0 and no tick: bright and state hold.
REQ-018 bright SHALL never wrap below 0 or exceed MAX.
REQ-019 leds[i] SHALL be registered as (pwm_cnt < bright[i]) using the current register values; bright=MAX gives constant 1 and bright=0 gives constant 0.
REQ-020 Latency: a din[i] rise sampled at edge k SHALL give leds[i]=1 after edge k+1.
REQ-021 busy SHALL be registered as the OR over channels of (state == FADE).
REQ-022 Channels SHALL be fully independent apart from the shared pwm_cnt and tick.
REQ-023 Fade duration from din fall to OFF SHALL be MAX ticks; the first decrement occurs on the first tick after the ON->FADE edge.

Reset
REQ-024 rstn=0 at a rising edge SHALL set pwm_cnt=0, prescaler=0, bright=0, every state OFF, leds=0 and busy=0, overriding all other inputs.
REQ-025 Reset asserted mid-fade SHALL abort the fade; after release every channel restarts from OFF and both counters restart from 0.
REQ-026 The first edge with rstn=1 SHALL sample din normally.

Structure
REQ-027 A shared include file SHALL hold the default values of N, PWM_BITS and DECAY_DIV and the 2-bit state encodings OFF=0, ON=1, FADE=2.
REQ-028 Sub-module ledfade_chan SHALL implement one channel: state, bright and PWM compare. ledfade SHALL instantiate it N times via generate, together with the shared PWM counter, prescaler and busy OR.
REQ-029 ledfade SHALL connect directly to the 5-bit sequencer LED output with no glue logic.

Verification (N=5, PWM_BITS=2 so MAX=3, DECAY_DIV=2, clock period 2)
REQ-030 Hold rstn=0 for 3 cycles with din=5'b11111 -> leds=0, busy=0 throughout; leds=5'b11111 two edges after release.
REQ-031 Step din[0] from 0 to 1 and hold -> leds[0]=1 from edge k+1 onward with no gaps; busy stays 0.
REQ-032 After din[0]=1, drop it to 0 -> busy=1; bright steps 3,2,1,0 on successive ticks; leds[0] duty per 3-cycle period is 3/3, 2/3, 1/3, then 0; state returns to OFF and busy=0.
REQ-033 Re-assert din[0] while bright=1 in FADE -> bright=3 on the next edge, state ON, busy falls.
REQ-034 Apply din=5'b10101 then din=5'b01010 -> channels 0, 2 and 4 fade in parallel while channels 1 and 3 are fully on; channels are independent.
REQ-035 Assert rstn=0 mid-fade with bright=2 -> all outputs 0 on the next edge; after release with din=0 everything stays OFF.
